usb_crc_tx_sequencer: RTL and testbench
=======================================

# usb_crc_tx_sequencer

Transmit-side packet sequencer that serialises a USB packet from a byte stream, LSb first, one bit per accepted downstream handshake. It drives the `usb_crc` unit over every bit after the PID byte, then appends the inverted CRC5 or CRC16, MSb first. It sits between the packet-buffer byte source and the bit-stuffing/NRZI stage in the SIE transmit path, in the 12 MHz domain.

## Interface
- No parameters.
- `clk12` in 1: 12 MHz clock.
- `RST` in 1: reset; synchronous, active-high.
- `txStart` in 1: start of packet. Accepted only in IDLE with `txByteValid`=1.
- `txCrcMode` in 2: CRC selection, sampled with `txStart`. 0 = none, 1 = CRC5, 2 = CRC16, 3 = treated as none.
- `txByte` in 8: byte data. The first byte of a packet is always the PID.
- `txByteValid` in 1: `txByte` is valid.
- `txByteLast` in 1: qualifies the current byte as the final data byte.
- `txLastBits` in 3: number of valid bits in the last byte, LSb-aligned; 0 means 8.
- `txByteReady` out 1: byte consumed this cycle (when `txByteValid`=1).
- `txBit` out 1: serial bit.
- `txBitValid` out 1: `txBit` is valid.
- `txBitReady` in 1: downstream accepts `txBit`. Low during stuff-bit insertion.
- `txBusy` out 1: high in any state except IDLE.
- `txDone` out 1: one-cycle pulse after the final bit is accepted.
- `txUnderrun` out 1: one-cycle pulse; the byte source starved mid-packet.

## Operation
- Reset values: all outputs 0; state IDLE; shift register, counters and CRC latch cleared.
- A bit is *accepted* on a cycle where `txBitValid` and `txBitReady` are both high.
- **IDLE:**
  - `txByteReady` = `txStart`.
  - On `txStart` && `txByteValid`: load the PID byte, latch the mode, pulse the CRC unit reset (`useCRC16` = mode==2), clear the CRC latch to 0, go to DATA.
  - `txStart` with `txByteValid`=0 is ignored.
- **DATA:**
  - Shift out the holding register LSb first.
  - `bitsLeft` starts at 8, or at `txLastBits` (0→8) when the byte is last.
  - `txByteReady` = !lastLoaded && (empty || (`bitsLeft`==1 && `txBitReady`)). This is a zero-bubble prefetch.
  - The CRC unit is fed only for accepted bits of non-PID bytes: VALID = accept && !pidByte, data = `txBit`.
  - The CRC latch captures the unit's `crc` output on every such cycle. That output is the inverted next-state value, so it is final on the last bit.
  - After the last bit of the last byte is accepted: go to CRC if mode is 1 or 2, else go to IDLE and assert `txDone`.
- **CRC:**
  - Shift out the latch MSb first: bit 4..0 for CRC5, bit 15..0 for CRC16.
  - `crcCnt` counts accepted bits.
  - After the final CRC bit is accepted: go to IDLE and assert `txDone`.
- **Underrun:** in DATA, if the register is empty and `txByteValid`=0, pulse `txUnderrun`, go to IDLE, and do not assert `txDone`.
- **PID-only packet with CRC enabled** (zero-length data): the latch stays 0, so an all-zero CRC is sent.

## Timing
- Latency: `txBitValid` goes high the cycle after `txStart`, with the PID bit 0.
- `txBitValid` stays high continuously in DATA and CRC, except on underrun.
- `txBit` and `txBitValid` hold while `txBitReady`=0. Stall length is unbounded.
- `txDone` and the return to IDLE occur together, one cycle after the final accept. `txBusy` drops in the same cycle.
- A new `txStart` is accepted in the same cycle `txDone` is high.
- `txStart` while busy is ignored.
- Byte transfer occurs on `txByteValid` && `txByteReady`. `txByte`, `txByteLast` and `txLastBits` are sampled only then.
- `RST` mid-packet: return to IDLE next edge, all outputs 0, no `txDone`/`txUnderrun`.
- `RST` has priority over all other events.

## Structure
- A shared SIE package holds:
  - the mode enum (`CRC_NONE`, `CRC_5`, `CRC_16`);
  - the state enum (`IDLE`, `DATA`, `CRC`);
  - the CRC width constants 5 and 16.
- One sub-module instance: `usb_crc`. Its `RST` is driven by the start cycle, `VALID` by the qualified accept, `data` by `txBit`. Its `validCRC` output is unused.

## Test plan
- SETUP token: PID 0x2D, byte 0x00, last byte 0x00 with `txLastBits`=3, CRC5, `txBitReady`=1 → wire shows the PID bits, then 11 zeros, then CRC bits 0,1,0,0,0. `txDone` fires one cycle after the 24th accept.
- Zero-length DATA1: PID 0x4B only, `txByteLast`=1, CRC16 → 8 PID bits followed by 16 zero bits.
- SETUP data: PID 0xC3, then 80 06 00 01 00 00 40 00, CRC16 → the trailing 16 bits equal bytes DD 94 sent LSb first. Random `txBitReady` stalls must not change the sequence.
- ACK: PID 0xD2, mode 0 → exactly 8 bits, `txDone`, no CRC bits.
- Underrun: drop `txByteValid` before the second data byte is needed → one `txUnderrun` pulse, IDLE, `txDone` never asserted.
- `RST` asserted during the CRC state → all outputs 0 next cycle. A subsequent ACK packet transmits correctly.

Source files
------------

// File: rtl/usb_crc_tx_sequencer_pkg.sv
// Shared SIE transmit types: CRC mode, sequencer state and CRC widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package usb_crc_tx_sequencer_pkg;

  typedef enum logic [1:0] {
    CRC_NONE = 2'd0,
    CRC_5    = 2'd1,
    CRC_16   = 2'd2
  } crc_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } tx_state_e;

  localparam int CRC5_W  = 5;
  localparam int CRC16_W = 16;

  // Encoding 3 is reserved on the wire side and behaves like "no CRC".
  function automatic crc_mode_e decode_crc_mode(input logic [1:0] m);
    case (m)
      2'd1:    return CRC_5;
      2'd2:    return CRC_16;
      default: return CRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc_tx_sequencer_if.sv
// Byte-in / bit-out handshake bundle of the SIE transmit sequencer.
// Latency: none (wires only).
// Backpressure: txByteReady toward the byte source, txBitReady from the stuffer.
interface usb_crc_tx_sequencer_if;
  logic       txStart;
  logic [1:0] txCrcMode;
  logic [7:0] txByte;
  logic       txByteValid;
  logic       txByteLast;
  logic [2:0] txLastBits;
  logic       txByteReady;
  logic       txBit;
  logic       txBitValid;
  logic       txBitReady;
  logic       txBusy;
  logic       txDone;
  logic       txUnderrun;

  modport master (
    output txStart, txCrcMode, txByte, txByteValid, txByteLast, txLastBits, txBitReady,
    input  txByteReady, txBit, txBitValid, txBusy, txDone, txUnderrun
  );

  modport slave (
    input  txStart, txCrcMode, txByte, txByteValid, txByteLast, txLastBits, txBitReady,
    output txByteReady, txBit, txBitValid, txBusy, txDone, txUnderrun
  );
endinterface

// File: rtl/usb_crc_tx_sequencer_crc.sv
// Serial USB CRC5/CRC16 generator, LSb-first data, all-ones preset on RST.
// Latency: crc is combinational (inverted next state); state updates on VALID.
module usb_crc
  import usb_crc_tx_sequencer_pkg::*;
(
  input  logic        clk12,
  input  logic        RST,
  input  logic        VALID,
  input  logic        data,
  input  logic        useCRC16,
  output logic [15:0] crc,
  output logic        validCRC
);

  logic [15:0] crc_q, crc_d;
  logic        use16_q, use16_d;
  logic [4:0]  nxt5;
  logic [15:0] nxt16;

  always_comb begin
    nxt5  = {crc_q[3:0], 1'b0} ^ ((data ^ crc_q[CRC5_W-1]) ? 5'h05 : 5'h00);
    nxt16 = {crc_q[14:0], 1'b0} ^ ((data ^ crc_q[CRC16_W-1]) ? 16'h8005 : 16'h0000);
    crc_d   = crc_q;
    use16_d = use16_q;
    if (VALID) begin
      crc_d = use16_q ? nxt16 : {crc_q[15:5], nxt5};
    end
    crc      = use16_q ? ~nxt16 : {11'd0, ~nxt5};
    // Residues of a received field including its CRC; kept for the receive path.
    validCRC = use16_q ? (crc_q == 16'h800D) : (crc_q[4:0] == 5'h0C);
  end

  always_ff @(posedge clk12) begin
    if (RST) begin
      crc_q   <= 16'hFFFF;
      use16_q <= useCRC16;
    end else begin
      crc_q   <= crc_d;
      use16_q <= use16_d;
    end
  end

endmodule

// File: rtl/usb_crc_tx_sequencer.sv
// Serialises PID + payload LSb first, then appends inverted CRC5/CRC16 MSb first.
// Latency: first bit valid the cycle after txStart; txDone one cycle after the last accept.
module usb_crc_tx_sequencer
  import usb_crc_tx_sequencer_pkg::*;
(
  input  logic                   clk12,
  input  logic                   RST,
  usb_crc_tx_sequencer_if.slave  bus
);

  tx_state_e   state_q, state_d;
  crc_mode_e   mode_q, mode_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  bits_left_q, bits_left_d;
  logic        last_loaded_q, last_loaded_d;
  logic        pid_q, pid_d;
  logic [15:0] crc_latch_q, crc_latch_d;
  logic [4:0]  crc_cnt_q, crc_cnt_d;
  logic        bit_q, bit_d, bit_vld_q, bit_vld_d;
  logic        busy_q, busy_d, done_q, done_d, underrun_q, underrun_d;

  logic        accept, byte_rdy, load, crc_start, crc_feed;
  logic [3:0]  load_bits, crc_msb;
  logic [15:0] crc_out;
  logic        crc_valid_unused;

  usb_crc u_crc (
    .clk12    (clk12),
    .RST      (RST | crc_start),
    .VALID    (crc_feed),
    .data     (bit_q),
    .useCRC16 (decode_crc_mode(bus.txCrcMode) == CRC_16),
    .crc      (crc_out),
    .validCRC (crc_valid_unused)
  );

  always_comb begin
    accept    = bit_vld_q && bus.txBitReady;
    crc_start = (state_q == IDLE) && bus.txStart && bus.txByteValid;
    crc_feed  = (state_q == DATA) && accept && !pid_q;
    crc_msb   = (mode_q == CRC_16) ? 4'(CRC16_W - 1) : 4'(CRC5_W - 1);
    load_bits = (bus.txByteLast && bus.txLastBits != 3'd0) ? {1'b0, bus.txLastBits} : 4'd8;

    case (state_q)
      IDLE:    byte_rdy = bus.txStart;
      // Fetch the next byte while the final bit of the current one is leaving.
      DATA:    byte_rdy = !last_loaded_q &&
                          (bits_left_q == 4'd0 || (bits_left_q == 4'd1 && bus.txBitReady));
      default: byte_rdy = 1'b0;
    endcase
    load = bus.txByteValid && byte_rdy;

    state_d       = state_q;
    mode_d        = mode_q;
    shreg_d       = shreg_q;
    bits_left_d   = bits_left_q;
    last_loaded_d = last_loaded_q;
    pid_d         = pid_q;
    crc_latch_d   = crc_latch_q;
    crc_cnt_d     = crc_cnt_q;
    bit_d         = bit_q;
    bit_vld_d     = bit_vld_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    underrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (crc_start) begin
          state_d     = DATA;
          mode_d      = decode_crc_mode(bus.txCrcMode);
          crc_latch_d = 16'd0;
          crc_cnt_d   = 5'd0;
          busy_d      = 1'b1;
        end
      end
      DATA: begin
        if (bits_left_q == 4'd0) begin
          if (!bus.txByteValid) begin
            state_d    = IDLE;
            underrun_d = 1'b1;
            busy_d     = 1'b0;
            bit_vld_d  = 1'b0;
            bit_d      = 1'b0;
          end
        end else if (accept) begin
          if (!pid_q) crc_latch_d = crc_out;
          if (bits_left_q == 4'd1) begin
            bits_left_d = 4'd0;
            if (last_loaded_q && mode_q != CRC_NONE) begin
              state_d   = CRC;
              crc_cnt_d = 5'd0;
              bit_d     = (mode_q == CRC_16) ? crc_latch_d[15] : crc_latch_d[4];
            end else begin
              // Refilled by the load below unless the source has starved.
              bit_vld_d = 1'b0;
              bit_d     = 1'b0;
              if (last_loaded_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
              end
            end
          end else begin
            shreg_d     = {1'b0, shreg_q[7:1]};
            bits_left_d = bits_left_q - 4'd1;
            bit_d       = shreg_q[1];
          end
        end
      end
      CRC: begin
        if (accept) begin
          crc_cnt_d = crc_cnt_q + 5'd1;
          if (crc_cnt_q == {1'b0, crc_msb}) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            bit_vld_d = 1'b0;
            bit_d     = 1'b0;
          end else begin
            bit_d = crc_latch_q[crc_msb - crc_cnt_q[3:0] - 4'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d       = bus.txByte;
      bits_left_d   = load_bits;
      last_loaded_d = bus.txByteLast;
      pid_d         = (state_q == IDLE);
      bit_d         = bus.txByte[0];
      bit_vld_d     = 1'b1;
    end
  end

  always_ff @(posedge clk12) begin
    if (RST) begin
      state_q       <= IDLE;
      mode_q        <= CRC_NONE;
      shreg_q       <= 8'd0;
      bits_left_q   <= 4'd0;
      last_loaded_q <= 1'b0;
      pid_q         <= 1'b0;
      crc_latch_q   <= 16'd0;
      crc_cnt_q     <= 5'd0;
      bit_q         <= 1'b0;
      bit_vld_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      shreg_q       <= shreg_d;
      bits_left_q   <= bits_left_d;
      last_loaded_q <= last_loaded_d;
      pid_q         <= pid_d;
      crc_latch_q   <= crc_latch_d;
      crc_cnt_q     <= crc_cnt_d;
      bit_q         <= bit_d;
      bit_vld_q     <= bit_vld_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bus.txByteReady = byte_rdy;
  assign bus.txBit       = bit_q;
  assign bus.txBitValid  = bit_vld_q;
  assign bus.txBusy      = busy_q;
  assign bus.txDone      = done_q;
  assign bus.txUnderrun  = underrun_q;

endmodule

// File: tb/tb_usb_crc_tx_sequencer.sv
// Directed packets against known USB wire images; a bit queue holds the expected stream.
module tb_usb_crc_tx_sequencer;

  logic clk12 = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] src_q[$];
  logic       exp_q[$];

  usb_crc_tx_sequencer_if bus();

  usb_crc_tx_sequencer dut (
    .clk12 (clk12),
    .RST   (rst),
    .bus   (bus.slave)
  );

  always #5 clk12 = ~clk12;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_byte_rdy"}, 32'(bus.txByteReady), 32'd0);
    check({tag, "_bit"},      32'(bus.txBit),       32'd0);
    check({tag, "_bit_vld"},  32'(bus.txBitValid),  32'd0);
    check({tag, "_busy"},     32'(bus.txBusy),      32'd0);
    check({tag, "_done"},     32'(bus.txDone),      32'd0);
    check({tag, "_underrun"}, 32'(bus.txUnderrun),  32'd0);
  endtask

  // Drives one packet from src_q, scoring every accepted bit against exp_q.
  task automatic run_pkt(input string tag, input logic [1:0] mode, input logic [2:0] lbits,
                         input bit stall, input int drop_at, input int rst_at,
                         input int exp_done, input int exp_under);
    int  idx = 0, cyc = 0, acc = 0, n_done = 0, n_under = 0;
    int  last_acc_cyc = -1, done_cyc = -1;
    bit  started = 0, rst_hit = 0, ended = 0;
    logic e;
    while (cyc < 3000) begin
      @(negedge clk12);
      cyc++;
      if (rst_hit) begin
        check_outputs_zero({tag, "_rst"});
        ended = 1;
        break;
      end
      if (bus.txDone) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.txUnderrun) n_under++;
      if (started && !bus.txBusy) begin
        ended = 1;
        break;
      end
      bus.txStart    = !started;
      bus.txCrcMode  = mode;
      bus.txBitReady = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (idx < src_q.size() && idx != drop_at) begin
        bus.txByteValid = 1'b1;
        bus.txByte      = src_q[idx];
        bus.txByteLast  = (idx == src_q.size() - 1);
        bus.txLastBits  = bus.txByteLast ? lbits : 3'($urandom);
      end else begin
        bus.txByteValid = 1'b0;
      end
      if (rst_at > 0 && acc == rst_at) begin
        rst     = 1'b1;
        rst_hit = 1;
        continue;
      end
      #1;
      if (bus.txBitValid && bus.txBitReady) begin
        acc++;
        last_acc_cyc = cyc;
        check({tag, "_bit_expected"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({tag, "_bit"}, 32'(bus.txBit), 32'(e));
        end
      end
      if (bus.txByteValid && bus.txByteReady) begin
        idx++;
        started = 1;
      end
    end
    check({tag, "_terminated"}, 32'(ended), 32'd1);
    check({tag, "_bits_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_cnt"}, 32'(n_done), 32'(exp_done));
    check({tag, "_underrun_cnt"}, 32'(n_under), 32'(exp_under));
    if (exp_done != 0) check({tag, "_done_delay"}, 32'(done_cyc - last_acc_cyc), 32'd1);
    bus.txStart     = 1'b0;
    bus.txByteValid = 1'b0;
    bus.txBitReady  = 1'b1;
    rst             = 1'b0;
    src_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.txStart     = 1'b0;
    bus.txCrcMode   = 2'd0;
    bus.txByte      = 8'd0;
    bus.txByteValid = 1'b0;
    bus.txByteLast  = 1'b0;
    bus.txLastBits  = 3'd0;
    bus.txBitReady  = 1'b1;

    repeat (3) @(negedge clk12);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Start without a valid byte must not launch a packet.
    bus.txStart = 1'b1;
    repeat (3) @(negedge clk12);
    check("start_novalid_busy", 32'(bus.txBusy), 32'd0);
    check("start_novalid_bitvld", 32'(bus.txBitValid), 32'd0);
    check("start_novalid_byte_rdy", 32'(bus.txByteReady), 32'd1);
    bus.txStart = 1'b0;

    // SETUP token, addr 0 endp 0: CRC5 field 0x02 on the wire.
    src_q = '{8'h2D, 8'h00, 8'h00};
    push_bits(16'h2D, 8); push_bits(16'h00, 8); push_bits(16'h00, 3); push_bits(16'h02, 5);
    run_pkt("setup_tok", 2'd1, 3'd3, 0, -1, 0, 1, 0);

    // Zero-length DATA1 with CRC16: all-zero CRC field.
    src_q = '{8'h4B};
    push_bits(16'h4B, 8); push_bits(16'h0000, 16);
    run_pkt("zlp_data1", 2'd2, 3'd0, 1, -1, 0, 1, 0);

    // GET_DESCRIPTOR setup data with stalls; CRC16 bytes DD 94.
    src_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    foreach (src_q[i]) push_bits(16'(src_q[i]), 8);
    push_bits(16'hDD, 8); push_bits(16'h94, 8);
    run_pkt("setup_data", 2'd2, 3'd0, 1, -1, 0, 1, 0);

    // ACK handshake, no CRC.
    src_q = '{8'hD2};
    push_bits(16'hD2, 8);
    run_pkt("ack", 2'd0, 3'd0, 0, -1, 0, 1, 0);

    // Source starves before the second data byte.
    src_q = '{8'hC3, 8'h11, 8'h22};
    push_bits(16'hC3, 8); push_bits(16'h11, 8);
    run_pkt("underrun", 2'd2, 3'd0, 0, 2, 0, 0, 1);

    // Reset two bits into the CRC5 field of a SETUP token.
    src_q = '{8'h2D, 8'h00, 8'h00};
    push_bits(16'h2D, 8); push_bits(16'h00, 8); push_bits(16'h00, 3); push_bits(16'h02, 2);
    run_pkt("rst_in_crc", 2'd1, 3'd3, 0, -1, 21, 0, 0);

    src_q = '{8'hD2};
    push_bits(16'hD2, 8);
    run_pkt("ack_after_rst", 2'd3, 3'd0, 1, -1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
